code_loader: RTL and testbench
==============================

Name: code_loader

Overview:
- Boot-time program loader that sits directly upstream of the processor datapath.
- Receives a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes the words into code memory through the datapath's `code_w_en` / `code_addr_in` / `code_in` port.
- Asserts `run` only after a complete frame with a correct checksum has been loaded.

Parameters:
- ADDR_W, 9, code memory address width; maximum word count is 2**ADDR_W = 512.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data holds a valid byte.
- rx_ready  output  1  loader can accept a byte this cycle.
- restart  input  1  single-cycle pulse: abort or leave RUN/ERROR and return to IDLE.
- code_w_en  output  1  code memory write strobe.
- code_addr_in  output  ADDR_W  code memory write address.
- code_in  output  16  code memory write data.
- run  output  1  processor run enable.
- busy  output  1  high in every state except IDLE, RUN and ERROR.
- error  output  1  frame rejected.

Behaviour:
- Reset is asynchronous and active-high. All outputs are registered.
- Reset values: state IDLE, rx_ready 1, code_w_en 0, code_addr_in 0, code_in 0, run 0, busy 0, error 0, count 0, checksum 0.
- A byte is accepted on a posedge where rx_valid & rx_ready.
- rx_ready is 1 in IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK and ERROR. It is 0 in WRITE and RUN.
- Frame format, byte order: SYNC, LEN_HI, LEN_LO, then LEN words each sent high byte first, then CHK.
- CHK is the XOR of LEN_HI, LEN_LO and all data bytes.
- States and transitions:
  - IDLE: a byte equal to SYNC_BYTE goes to LEN_HI and clears checksum and address. Any other byte is discarded.
  - LEN_HI / LEN_LO: latch the 16-bit length. After LEN_LO:
    - length == 0 or length > 2**ADDR_W goes to ERROR.
    - otherwise go to DATA_HI.
  - DATA_HI: latch the high byte and go to DATA_LO.
  - DATA_LO: latch the low byte and go to WRITE.
  - WRITE: exactly one cycle with code_w_en=1, code_in={hi,lo}, code_addr_in = current address.
    - Next cycle: address increments and remaining count decrements.
    - If the remaining count was 1, go to CHECK; else go to DATA_HI.
  - CHECK: the received byte equal to the running XOR goes to RUN; a mismatch goes to ERROR.
  - RUN: run=1, held until restart.
  - ERROR: error=1, run=0, held until restart. Incoming bytes are accepted and dropped so the sender never stalls.
- restart:
  - In any state, restart goes to IDLE on the next posedge and clears run, error, address, count and checksum.
  - restart takes priority over a simultaneous byte acceptance; that byte is dropped.
- Checksum updates on every accepted byte in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
- Address wrap: cannot occur. A length of 512 writes addresses 0..511 and the counter is never used past 511.
- Reset mid-load:
  - Returns immediately to reset values.
  - Words already written stay in code memory.
  - run stays 0 until a full valid frame completes.
- Latency:
  - The write strobe occurs 1 cycle after the low byte is accepted.
  - run rises 1 cycle after the CHK byte is accepted.

Test Plan:
- Frame A5 00 02 12 34 AB CD, CHK = 00^02^12^34^AB^CD = 0x42, no stalls:
  - expect writes (0,0x1234) then (1,0xABCD), each code_w_en one cycle wide;
  - run=1 one cycle after CHK; error=0.
- Same frame with CHK=0x43 -> two writes occur, run stays 0, error=1, rx_ready stays 1. restart -> error=0, state IDLE.
- Leading garbage 00 FF 5A, then a valid 1-word frame A5 00 01 BE EF CHK(=0x01^0xBE^0xEF=0x50) -> garbage ignored; single write (0,0xBEEF); run=1.
- Length 00 00 -> error=1 and no write. Length 02 01 (513) -> error=1 and no write.
- Reset asserted after the first data word's WRITE of a 3-word frame -> outputs go to reset values immediately with no clock edge; a later valid frame loads normally from address 0.
- 512-word frame with random rx_valid gaps -> 512 writes at addresses 0..511 with no duplicates or skips; run=1; rx_ready=0 during every WRITE cycle.

Source files
------------

// File: rtl/code_loader_if.sv
// Byte-stream input and code-memory write port of the boot loader.
//
// Handshake: a byte moves from master to slave on a rising clock edge where
// rx_valid and rx_ready are both high. The master holds rx_data stable while
// rx_valid is high and the byte has not moved yet. rx_ready may change whether
// or not rx_valid is high. restart is a one-cycle pulse from the master.
interface code_loader_if #(
   parameter int ADDR_W = 9
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              restart;
   logic              code_w_en;
   logic [ADDR_W-1:0] code_addr_in;
   logic [15:0]       code_in;
   logic              run;
   logic              busy;
   logic              error;

   // Byte source / system controller side
   modport master (
      output rx_data, rx_valid, restart,
      input  rx_ready, code_w_en, code_addr_in, code_in, run, busy, error
   );

   // Loader side
   modport slave (
      input  rx_data, rx_valid, restart,
      output rx_ready, code_w_en, code_addr_in, code_in, run, busy, error
   );
endinterface

// File: rtl/code_loader.sv
// Boot-time program loader: takes a framed byte stream (SYNC, LEN_HI, LEN_LO,
// LEN big-endian 16-bit words, CHK), writes the words into code memory from
// address 0 and raises run only when the XOR checksum of LEN and data matches.
module code_loader #(
   parameter int          ADDR_W    = 9,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst,
   code_loader_if.slave         bus,
   output logic [3:0]           o_dbg_state
);

   // Count register is one bit wider than the address so that a full
   // 2**ADDR_W-word frame can be represented.
   localparam int          CNT_W   = ADDR_W + 1;
   localparam logic [15:0] MAX_LEN = 16'(2 ** ADDR_W);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_LEN_HI  = 4'd1,
      S_LEN_LO  = 4'd2,
      S_DATA_HI = 4'd3,
      S_DATA_LO = 4'd4,
      S_WRITE   = 4'd5,
      S_CHECK   = 4'd6,
      S_RUN     = 4'd7,
      S_ERROR   = 4'd8
   } state_t;

   state_t            r_state;
   logic [7:0]        r_len_hi;
   logic [7:0]        r_hi;
   logic [CNT_W-1:0]  r_count;
   logic [7:0]        r_chk;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_code_in;
   logic              r_w_en;
   logic              r_rx_ready;
   logic              r_run;
   logic              r_busy;
   logic              r_error;

   logic              w_accept;
   logic [15:0]       w_len;

   assign w_accept = bus.rx_valid & r_rx_ready;
   assign w_len    = {r_len_hi, bus.rx_data};

   // Frame-parsing FSM; every output is registered and set on the transition
   // into the state that owns it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_len_hi   <= 8'd0;
         r_hi       <= 8'd0;
         r_count    <= '0;
         r_chk      <= 8'd0;
         r_addr     <= '0;
         r_code_in  <= 16'd0;
         r_w_en     <= 1'b0;
         r_rx_ready <= 1'b1;
         r_run      <= 1'b0;
         r_busy     <= 1'b0;
         r_error    <= 1'b0;
      end else if (bus.restart) begin
         // Restart wins over any byte offered in the same cycle.
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_chk      <= 8'd0;
         r_addr     <= '0;
         r_w_en     <= 1'b0;
         r_rx_ready <= 1'b1;
         r_run      <= 1'b0;
         r_busy     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept && (bus.rx_data == SYNC_BYTE)) begin
                  r_state <= S_LEN_HI;
                  r_chk   <= 8'd0;
                  r_addr  <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_LEN_HI: begin
               if (w_accept) begin
                  r_len_hi <= bus.rx_data;
                  r_chk    <= r_chk ^ bus.rx_data;
                  r_state  <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (w_accept) begin
                  r_chk <= r_chk ^ bus.rx_data;
                  if ((w_len == 16'd0) || (w_len > MAX_LEN)) begin
                     r_state <= S_ERROR;
                     r_error <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_count <= w_len[CNT_W-1:0];
                     r_state <= S_DATA_HI;
                  end
               end
            end
            S_DATA_HI: begin
               if (w_accept) begin
                  r_hi    <= bus.rx_data;
                  r_chk   <= r_chk ^ bus.rx_data;
                  r_state <= S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               if (w_accept) begin
                  r_chk      <= r_chk ^ bus.rx_data;
                  r_code_in  <= {r_hi, bus.rx_data};
                  r_w_en     <= 1'b1;
                  r_rx_ready <= 1'b0;
                  r_state    <= S_WRITE;
               end
            end
            S_WRITE: begin
               // The strobe was high for this one cycle; advance to next word.
               r_w_en     <= 1'b0;
               r_rx_ready <= 1'b1;
               r_addr     <= r_addr + 1'b1;
               r_count    <= r_count - 1'b1;
               r_state    <= (r_count == CNT_W'(1)) ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: begin
               if (w_accept) begin
                  r_busy <= 1'b0;
                  if (bus.rx_data == r_chk) begin
                     r_state    <= S_RUN;
                     r_run      <= 1'b1;
                     r_rx_ready <= 1'b0;
                  end else begin
                     r_state <= S_ERROR;
                     r_error <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               r_state <= S_RUN;
            end
            S_ERROR: begin
               // Bytes keep being accepted (rx_ready high) and are dropped.
               r_state <= S_ERROR;
            end
            default: begin
               r_state    <= S_IDLE;
               r_rx_ready <= 1'b1;
               r_w_en     <= 1'b0;
               r_run      <= 1'b0;
               r_busy     <= 1'b0;
               r_error    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx_ready     = r_rx_ready;
   assign bus.code_w_en    = r_w_en;
   assign bus.code_addr_in = r_addr;
   assign bus.code_in      = r_code_in;
   assign bus.run          = r_run;
   assign bus.busy         = r_busy;
   assign bus.error        = r_error;
   assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: randomized frames, a byte-level frame
// model producing the expected list of code-memory writes, and a write monitor.
module tb_code_loader;

   localparam int ADDR_W = 9;

   logic       clk;
   logic       rst;
   logic [3:0] dbg_state;

   code_loader_if #(.ADDR_W(ADDR_W)) bus ();

   code_loader #(
      .ADDR_W    (ADDR_W),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [24:0] exp_q[$];          // {addr[8:0], data[15:0]}
   logic [15:0] words[$];          // payload of the frame being built

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Every write strobe must match the next entry of the expected write list.
   always @(negedge clk) begin
      if (!rst && bus.code_w_en) begin
         if (exp_q.size() == 0) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
         end else begin
            logic [24:0] e;
            e = exp_q.pop_front();
            check("write_addr", 32'(bus.code_addr_in), 32'(e[24:16]));
            check("write_data", 32'(bus.code_in), 32'(e[15:0]));
            check("ready_in_write", 32'(bus.rx_ready), 32'd0);
         end
      end
   end

   // ---------------- driver tasks (start and end on a negedge) ----------------
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int gap;
      int guard;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      guard = 0;
      while (!bus.rx_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic do_restart();
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      check("restart_run", 32'(bus.run), 32'd0);
      check("restart_error", 32'(bus.error), 32'd0);
      check("restart_busy", 32'(bus.busy), 32'd0);
      check("restart_ready", 32'(bus.rx_ready), 32'd1);
   endtask

   task automatic fill_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
   endtask

   task automatic check_reset_values();
      check("rst_ready", 32'(bus.rx_ready), 32'd1);
      check("rst_wen", 32'(bus.code_w_en), 32'd0);
      check("rst_addr", 32'(bus.code_addr_in), 32'd0);
      check("rst_code_in", 32'(bus.code_in), 32'd0);
      check("rst_run", 32'(bus.run), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_error", 32'(bus.error), 32'd0);
   endtask

   // Reference model: builds the byte stream from the frame rules, computes
   // the XOR checksum over the bytes and predicts writes and final status.
   task automatic load_frame(input logic [15:0] len, input logic [7:0] chk_mask, input int gap);
      logic [7:0] chk;
      bit         len_ok;
      len_ok = (len != 16'd0) && (len <= 16'd512);
      chk = len[15:8] ^ len[7:0];
      send_byte(8'hA5, gap);
      send_byte(len[15:8], gap);
      send_byte(len[7:0], gap);
      if (!len_ok) begin
         check("len_error", 32'(bus.error), 32'd1);
         check("len_busy", 32'(bus.busy), 32'd0);
         send_byte(8'h3C, gap);
         check("len_err_ready", 32'(bus.rx_ready), 32'd1);
         check("len_err_hold", 32'(bus.error), 32'd1);
         return;
      end
      check("busy_loading", 32'(bus.busy), 32'd1);
      for (int i = 0; i < int'(len); i++) begin
         chk = chk ^ words[i][15:8] ^ words[i][7:0];
         exp_q.push_back({9'(i), words[i]});
         send_byte(words[i][15:8], gap);
         send_byte(words[i][7:0], gap);
         check("wen_latency", 32'(bus.code_w_en), 32'd1);
      end
      send_byte(chk ^ chk_mask, gap);
      check("run_after_chk", 32'(bus.run), 32'(chk_mask == 8'd0));
      check("error_after_chk", 32'(bus.error), 32'(chk_mask != 8'd0));
      check("ready_after_chk", 32'(bus.rx_ready), 32'(chk_mask != 8'd0));
      @(negedge clk);
      check("pending_writes", 32'(exp_q.size()), 32'd0);
      if (chk_mask != 8'd0) begin
         // Error state swallows further bytes without stalling.
         send_byte(8'hA5, 0);
         send_byte(8'h00, 0);
         check("err_hold", 32'(bus.error), 32'd1);
         check("err_no_run", 32'(bus.run), 32'd0);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst          = 1'b1;
      bus.rx_data  = 8'd0;
      bus.rx_valid = 1'b0;
      bus.restart  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values();
      rst = 1'b0;
      @(negedge clk);

      // Two-word frame, no stalls, correct checksum (0x42).
      words.delete();
      words.push_back(16'h1234);
      words.push_back(16'hABCD);
      load_frame(16'd2, 8'h00, 0);
      check("run_hold", 32'(bus.run), 32'd1);
      check("run_ready", 32'(bus.rx_ready), 32'd0);
      do_restart();

      // Same frame, checksum 0x43: writes still happen, then error.
      load_frame(16'd2, 8'h01, 0);
      do_restart();

      // Leading garbage, then a one-word frame.
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h5A, 0);
      check("garbage_idle", 32'(bus.busy), 32'd0);
      words.delete();
      words.push_back(16'hBEEF);
      load_frame(16'd1, 8'h00, 0);
      do_restart();

      // Length boundaries: 0 and 513 rejected.
      load_frame(16'h0000, 8'h00, 0);
      do_restart();
      load_frame(16'h0201, 8'h00, 0);
      do_restart();

      // Restart colliding with a SYNC byte: byte dropped, loader stays idle,
      // so the following bytes are garbage and nothing is written.
      bus.rx_data  = 8'hA5;
      bus.rx_valid = 1'b1;
      bus.restart  = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.restart  = 1'b0;
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hBE, 0);
      check("restart_drops_sync", 32'(bus.busy), 32'd0);

      // Restart in the middle of a frame aborts it.
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      do_restart();

      // Asynchronous reset after the first word of a 3-word frame.
      fill_words(3);
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h03, 0);
      exp_q.push_back({9'd0, words[0]});
      send_byte(words[0][15:8], 0);
      send_byte(words[0][7:0], 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_values();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_drain", 32'(exp_q.size()), 32'd0);
      load_frame(16'd3, 8'h00, 1);
      do_restart();

      // Randomized frames, lengths, gaps and checksum corruption.
      for (int t = 0; t < 20; t++) begin
         int          n;
         logic [7:0]  mask;
         n = int'($urandom_range(1, 8));
         mask = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         fill_words(n);
         load_frame(16'(n), mask, int'($urandom_range(0, 3)));
         do_restart();
      end

      // Full 512-word frame with random valid gaps.
      fill_words(512);
      load_frame(16'd512, 8'h00, 2);
      do_restart();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
